// File: rtl/serial_word_comparator.sv
// Bit-serial magnitude comparator for framed WIDTH-bit words, MSB/LSB-first, unsigned/signed.
// Registered less/great/equal verdict, bit counter, busy and one-cycle done pulse.
module serial_word_comparator #(
   parameter int unsigned WIDTH             = 8,
   parameter bit          MSB_FIRST_DEFAULT = 1'b1
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_start,
   input  logic                     i_valid,
   input  logic                     i_a,
   input  logic                     i_b,
   input  logic                     i_mode_override,
   input  logic                     i_lsb_first,
   input  logic                     i_signed_mode,
   output logic                     o_less_out,
   output logic                     o_great_out,
   output logic                     o_equal_out,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [$clog2(WIDTH)-1:0] o_bit_count
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

   typedef enum logic {StIdle, StRun} state_e;

   state_e        r_state, w_state_d;
   logic [CW-1:0] r_bit_count, w_bit_count_d;
   logic          r_less, w_less_d;
   logic          r_great, w_great_d;
   logic          r_done, w_done_d;
   logic          r_lsb, w_lsb_d;
   logic          r_signed, w_signed_d;

   logic w_consume;
   logic w_word_end;
   logic w_last_bit;
   logic w_lsb_sel;
   logic w_sgn_sel;
   logic w_prev_less;
   logic w_prev_great;

   always_comb begin
      w_state_d     = r_state;
      w_bit_count_d = r_bit_count;
      w_less_d      = r_less;
      w_great_d     = r_great;
      w_done_d      = 1'b0;
      w_lsb_d       = r_lsb;
      w_signed_d    = r_signed;

      w_consume  = i_valid && (i_start || (r_state == StRun));
      w_word_end = (r_state == StRun) && (r_bit_count == LastIdx);
      // A start bit always begins a new word, so it is never the final bit of one.
      w_last_bit = w_word_end && !i_start;

      w_lsb_sel    = i_start ? (i_mode_override ? i_lsb_first : !MSB_FIRST_DEFAULT) : r_lsb;
      w_sgn_sel    = i_start ? i_signed_mode : r_signed;
      w_prev_less  = i_start ? 1'b0 : r_less;
      w_prev_great = i_start ? 1'b0 : r_great;

      if (w_consume) begin
         w_done_d = w_word_end;
         if (i_start) begin
            w_state_d     = StRun;
            w_bit_count_d = CW'(1);
            w_lsb_d       = w_lsb_sel;
            w_signed_d    = w_sgn_sel;
         end else if (w_word_end) begin
            w_state_d     = StIdle;
            w_bit_count_d = '0;
         end else begin
            w_bit_count_d = r_bit_count + CW'(1);
         end

         w_less_d  = w_prev_less;
         w_great_d = w_prev_great;
         if (i_a != i_b) begin
            if (w_lsb_sel) begin
               // Later bits carry more weight; the sign bit arrives last and inverts the sense.
               w_great_d = i_a ^ (w_sgn_sel & w_last_bit);
               w_less_d  = !w_great_d;
            end else if (!w_prev_less && !w_prev_great) begin
               w_great_d = i_a ^ (w_sgn_sel & i_start);
               w_less_d  = !w_great_d;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= StIdle;
         r_bit_count <= '0;
         r_less      <= 1'b0;
         r_great     <= 1'b0;
         r_done      <= 1'b0;
         r_lsb       <= !MSB_FIRST_DEFAULT;
         r_signed    <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_bit_count <= w_bit_count_d;
         r_less      <= w_less_d;
         r_great     <= w_great_d;
         r_done      <= w_done_d;
         r_lsb       <= w_lsb_d;
         r_signed    <= w_signed_d;
      end
   end

   assign o_less_out  = r_less;
   assign o_great_out = r_great;
   assign o_equal_out = !(r_less || r_great);
   assign o_busy      = (r_state == StRun);
   assign o_done      = r_done;
   assign o_bit_count = r_bit_count;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Self-checking bench for serial_word_comparator: directed plan cases plus random words
// checked against an arithmetic prefix-comparison model.
module tb_serial_word_comparator;

   localparam int unsigned W       = 8;
   localparam int unsigned CW      = $clog2(W);
   localparam bit          MSB_DEF = 1'b1;

   logic          clk = 1'b0;
   logic          i_reset;
   logic          i_start, i_valid, i_a, i_b;
   logic          i_mode_override, i_lsb_first, i_signed_mode;
   logic          o_less_out, o_great_out, o_equal_out, o_busy, o_done;
   logic [CW-1:0] o_bit_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_word_comparator #(
      .WIDTH             (W),
      .MSB_FIRST_DEFAULT (MSB_DEF)
   ) dut (
      .i_clk           (clk),
      .i_reset         (i_reset),
      .i_start         (i_start),
      .i_valid         (i_valid),
      .i_a             (i_a),
      .i_b             (i_b),
      .i_mode_override (i_mode_override),
      .i_lsb_first     (i_lsb_first),
      .i_signed_mode   (i_signed_mode),
      .o_less_out      (o_less_out),
      .o_great_out     (o_great_out),
      .o_equal_out     (o_equal_out),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_bit_count     (o_bit_count)
   );

   // Compare the portion of each operand seen after k bits as plain integers.
   function automatic int ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit lsb, input bit sgn, input int k);
      longint pa, pb;
      if (!lsb) begin
         pa = longint'(a >> (W - k));
         pb = longint'(b >> (W - k));
         if (sgn && ((pa >> (k - 1)) & 1) != 0) pa = pa - (longint'(1) << k);
         if (sgn && ((pb >> (k - 1)) & 1) != 0) pb = pb - (longint'(1) << k);
      end else begin
         pa = longint'(a) & ((longint'(1) << k) - 1);
         pb = longint'(b) & ((longint'(1) << k) - 1);
         if (sgn && k == W && ((pa >> (W - 1)) & 1) != 0) pa = pa - (longint'(1) << W);
         if (sgn && k == W && ((pb >> (W - 1)) & 1) != 0) pb = pb - (longint'(1) << W);
      end
      if (pa < pb) return -1;
      if (pa > pb) return 1;
      return 0;
   endfunction

   // {less, great, equal}
   function automatic logic [2:0] enc(input int c);
      if (c < 0) return 3'b100;
      if (c > 0) return 3'b010;
      return 3'b001;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [2:0] ev, input int bc,
                              input bit busy, input bit done);
      chk({tag, " verdict"}, {29'd0, o_less_out, o_great_out, o_equal_out}, {29'd0, ev});
      chk({tag, " bit_count"}, 32'(o_bit_count), 32'(bc));
      chk({tag, " busy"}, {31'd0, o_busy}, {31'd0, busy});
      chk({tag, " done"}, {31'd0, o_done}, {31'd0, done});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Streams nbits of A/B as a word; mode inputs are scrambled on non-start cycles.
   task automatic run_word(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit ovr, input bit lsb, input bit sgn, input int nbits,
                           input bit prev_ends, input int stall_at, input int stall_len);
      bit         eff_lsb;
      int         idx, k;
      logic [2:0] ev;
      eff_lsb = ovr ? lsb : !MSB_DEF;
      ev = 3'b001;
      for (int i = 0; i < nbits; i++) begin
         idx = eff_lsb ? i : (W - 1 - i);
         i_valid = 1'b1;
         i_start = (i == 0);
         i_a = a[idx];
         i_b = b[idx];
         if (i == 0) begin
            i_mode_override = ovr;
            i_lsb_first     = lsb;
            i_signed_mode   = sgn;
         end else begin
            i_mode_override = 1'($urandom);
            i_lsb_first     = 1'($urandom);
            i_signed_mode   = 1'($urandom);
         end
         cyc();
         k = i + 1;
         ev = enc(ref_cmp(a, b, eff_lsb, sgn, k));
         check_state(tag, ev, (k < W) ? k : 0, k < W, (i == 0) ? prev_ends : (k == W));
         if (i == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               i_valid = 1'b0;
               i_start = 1'($urandom);
               i_a     = 1'($urandom);
               i_b     = 1'($urandom);
               cyc();
               check_state({tag, " stall"}, ev, k, 1'b1, 1'b0);
            end
         end
      end
      if (nbits == W) begin
         i_valid = 1'b0;
         i_start = 1'b0;
         cyc();
         check_state({tag, " hold"}, ev, 0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      i_reset = 1'b0;
      i_start = 1'b0;
      i_valid = 1'b0;
      i_a = 1'b0;
      i_b = 1'b0;
      i_mode_override = 1'b0;
      i_lsb_first = 1'b0;
      i_signed_mode = 1'b0;
      #1;
      check_state("reset", 3'b001, 0, 1'b0, 1'b0);
      cyc();
      i_reset = 1'b1;
      cyc();

      run_word("msb_u 5A/5B", 8'h5A, 8'h5B, 1'b0, 1'b0, 1'b0, W, 1'b0, -1, 0);
      run_word("lsb_u 80/7F", 8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, W, 1'b0, -1, 0);
      run_word("msb_s 80/01", 8'h80, 8'h01, 1'b1, 1'b0, 1'b1, W, 1'b0, -1, 0);
      run_word("lsb_s 80/01", 8'h80, 8'h01, 1'b1, 1'b1, 1'b1, W, 1'b0, -1, 0);
      run_word("stall C3", 8'hC3, 8'hC3, 1'b0, 1'b0, 1'b0, W, 1'b0, 3, 3);

      run_word("abort old", 8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 4, 1'b0, -1, 0);
      run_word("abort new", 8'h9C, 8'h9A, 1'b1, 1'b0, 1'b1, W, 1'b0, -1, 0);

      run_word("overlap old", 8'h11, 8'hEE, 1'b0, 1'b0, 1'b0, W - 1, 1'b0, -1, 0);
      run_word("overlap new", 8'hF0, 8'h0F, 1'b1, 1'b1, 1'b1, W, 1'b1, -1, 0);

      // Asynchronous reset in the middle of a cycle, then start-less bits are ignored.
      run_word("pre reset", 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, 5, 1'b0, -1, 0);
      #2;
      i_reset = 1'b0;
      #1;
      check_state("async reset", 3'b001, 0, 1'b0, 1'b0);
      cyc();
      i_reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_valid = 1'b1;
         i_start = 1'b0;
         i_a = 1'b1;
         i_b = 1'b0;
         cyc();
         check_state("idle ignore", 3'b001, 0, 1'b0, 1'b0);
      end

      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom);
         rb = (n % 4 == 0) ? ra : W'($urandom);
         run_word("random", ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), W, 1'b0,
                  (n % 3 == 0) ? int'($urandom_range(W - 2, 0)) : -1,
                  int'($urandom_range(3, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_word_comparator.md
Name: serial_word_comparator

Overview:
Parametrised bit-serial magnitude comparator. It compares two WIDTH-bit words streamed one bit per valid cycle and supports MSB-first or LSB-first order, and unsigned or two's-complement mode. It tracks word framing with an internal bit counter and flags completion. It is the framed, mode-configurable successor to the team's single-stream serial comparator, used wherever serial operand pairs need a registered less/greater/equal verdict per word.

Parameters:
WIDTH, 8, bits per word (>=2); counter width is clog2(WIDTH)
MSB_FIRST_DEFAULT, 1, mode applied when mode_override=0 (1 = MSB first)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  marks the first bit of a word; only meaningful with valid=1
valid  input  1  a/b carry a bit this cycle
a  input  1  serial bit of operand A
b  input  1  serial bit of operand B
mode_override  input  1  1 = use lsb_first input instead of MSB_FIRST_DEFAULT
lsb_first  input  1  1 = LSB-first order (sampled at start)
signed_mode  input  1  1 = two's complement (sampled at start)
less_out  output  1  A < B (running verdict, registered)
great_out  output  1  A > B
equal_out  output  1  A == B so far
busy  output  1  word in progress
done  output  1  one-cycle pulse: final verdict valid
bit_count  output  clog2(WIDTH)  bits consumed in the current word

Behaviour:
- Reset (reset=0, async): less_out=0, great_out=0, equal_out=1, busy=0, done=0, bit_count=0, state IDLE. Mode registers clear to unsigned, MSB_FIRST_DEFAULT.
- Invariant: exactly one of less/great/equal is 1 at all times.
- States: IDLE, RUN.
  - IDLE -> RUN on valid&start.
  - RUN -> IDLE when the bit with bit_count==WIDTH-1 is consumed.
- Bit consumption (valid=1 and (start or RUN)), all updates on the same clk edge:
  - start=1: order and signed mode latch from the inputs; the verdict is computed from this bit alone with prior state treated as equal; bit_count <- 1.
  - Otherwise bit_count increments.
- MSB-first unsigned:
  - If equal and a!=b: a=1 -> great, a=0 -> less.
  - Once unequal, the verdict is sticky for the rest of the word.
- MSB-first signed: the first bit is the sign. If it differs, the sense is inverted (a=1 -> less). Remaining bits follow the unsigned rule.
- LSB-first unsigned: every differing bit overwrites the verdict (a=1 -> great, a=0 -> less). Equal bits keep the verdict.
- LSB-first signed: as unsigned, except the last bit (bit_count==WIDTH-1) uses the inverted sense when a!=b.
- done: asserts for one cycle in the cycle after the last bit is consumed. The verdict then holds unchanged until the next start.
- busy: 1 while in RUN.
- valid=0 in RUN: stall. No state change, counter holds, verdict holds.
- valid=1, start=0 in IDLE: bit ignored, no output change.
- start=1 mid-word (RUN): abort the current word and restart with this bit. No done is generated for the aborted word.
- start=1 on the same cycle as a word's last bit completes: the new word begins. done still pulses next cycle for the completed word, and the outputs show the new word's first-bit verdict.
- Mode inputs are ignored except on start cycles.
- Async reset mid-word: immediate return to reset values.

Test Plan:
- WIDTH=8, unsigned MSB-first, A=0x5A, B=0x5B -> equal_out=1 through bit 6, less_out=1 after bit 7; done pulses once the cycle after bit 7; busy drops the same cycle.
- Unsigned LSB-first, A=0x80, B=0x7F -> verdict toggles to less at bit 0, stays less through bit 6, becomes great at bit 7; final great_out=1.
- Signed MSB-first, A=0x80 (-128), B=0x01 -> less_out=1 after the first bit; signed LSB-first with the same operands -> final less_out=1 after the sign bit overrides.
- A=B=0xC3 with valid deasserted for 3 cycles mid-word -> bit_count and the verdict freeze during the stall; final equal_out=1; done pulses exactly once.
- start reasserted at bit 4 of a word -> bit_count returns to 1, no done for the aborted word, a fresh 8-bit compare completes correctly.
- Assert reset low at bit 5 -> outputs immediately read equal=1, less=0, great=0, busy=0, bit_count=0; valid bits without start are then ignored.
